// File: rtl/commit_pkg.sv
// Shared types for the commit checker: normalised commit record, checker FSM states,
// mismatch codes and the store-lane normalisation helper.
package commit_pkg;

   typedef enum logic {
      KIND_REG = 1'b0,
      KIND_MEM = 1'b1
   } rec_kind_e;

   typedef struct packed {
      rec_kind_e   kind;
      logic [31:0] pc;
      logic [31:0] inst;
      logic [5:0]  rd;
      logic [31:0] addr;
      logic [31:0] data;
      logic        last;
   } commit_rec_t;

   typedef enum logic [1:0] {
      CHECK = 2'd0,
      FAIL  = 2'd1,
      DONE  = 2'd2
   } chk_state_e;

   localparam logic [2:0] MIS_NONE      = 3'd0;
   localparam logic [2:0] MIS_PC        = 3'd1;
   localparam logic [2:0] MIS_INST      = 3'd2;
   localparam logic [2:0] MIS_RDADDR    = 3'd3;
   localparam logic [2:0] MIS_DATA      = 3'd4;
   localparam logic [2:0] MIS_KIND      = 3'd5;
   localparam logic [2:0] MIS_UNDERFLOW = 3'd6;

   localparam logic [4:0] BRANCH = 5'b11000;

   // Store data arrives lane-aligned; golden data is right-justified and sized by funct3.
   function automatic logic [31:0] store_lane(input logic [31:0] data,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  funct3);
      logic [31:0] shifted;
      shifted = data >> {lane, 3'b000};
      case (funct3)
         3'b000:  return {24'h0, shifted[7:0]};
         3'b001:  return {16'h0, shifted[15:0]};
         default: return shifted;
      endcase
   endfunction

endpackage

// File: rtl/commit_rec_fifo.sv
// Golden-record FIFO: registered write, head visible combinationally, zero-latency pop.
// Push is dropped when full (even with a same-cycle pop); pop is ignored when empty.
module commit_rec_fifo
   import commit_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  commit_rec_t push_rec,
   input  logic        pop,
   output commit_rec_t head,
   output logic        full,
   output logic        empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   commit_rec_t mem [DEPTH];
   logic        push_ok;
   logic        pop_ok;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= push_rec;
   end

endmodule

// File: rtl/commit_checker.sv
// Compares retired commits against a golden trace: normalise at edge N, compare/pop at N+1,
// errors visible the cycle after; gold_ready drops when full or once FAIL/DONE is reached.
module commit_checker
   import commit_pkg::*;
#(
   parameter int          DEPTH   = 8,
   parameter logic [31:0] PC_BASE = 32'h2000,
   parameter int          CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             commit_valid,
   input  logic [31:0]      commit_pc,
   input  logic [31:0]      commit_inst,
   input  logic [5:0]       commit_Ard,
   input  logic [31:0]      commit_data,
   input  logic             st_commit,
   input  logic [31:0]      st_addr,
   input  logic [31:0]      st_data,
   input  logic             gold_valid,
   output logic             gold_ready,
   input  logic             gold_kind,
   input  logic [31:0]      gold_pc,
   input  logic [31:0]      gold_inst,
   input  logic [5:0]       gold_rd,
   input  logic [31:0]      gold_addr,
   input  logic [31:0]      gold_data,
   input  logic             gold_last,
   output logic             mismatch,
   output logic [2:0]       mis_code,
   output logic [31:0]      mis_pc,
   output logic [CNT_W-1:0] match_count,
   output logic             done
);

   chk_state_e  state_q;
   chk_state_e  state_d;
   commit_rec_t push_rec;
   commit_rec_t head;
   logic        full;
   logic        empty;
   logic        push;
   logic        pop;

   logic        s1_take;
   logic        s1_vld;
   rec_kind_e   s1_kind;
   logic [31:0] s1_pc;
   logic [31:0] s1_inst;
   logic [5:0]  s1_rd;
   logic [31:0] s1_addr;
   logic [31:0] s1_data;

   logic [2:0]  chk_code;
   logic        matched;

   assign gold_ready = !full && (state_q == CHECK);
   assign push       = gold_valid && gold_ready;
   assign push_rec   = '{kind: rec_kind_e'(gold_kind), pc: gold_pc, inst: gold_inst,
                         rd: gold_rd, addr: gold_addr, data: gold_data, last: gold_last};

   commit_rec_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_rec (push_rec),
      .pop      (pop),
      .head     (head),
      .full     (full),
      .empty    (empty)
   );

   // Branches and x0 writes produce no golden record; stores always do.
   assign s1_take = commit_valid && (commit_pc >= PC_BASE) &&
                    (st_commit || ((commit_Ard != 6'd0) && (commit_inst[6:2] != BRANCH)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_vld  <= 1'b0;
         s1_kind <= KIND_REG;
         s1_pc   <= '0;
         s1_inst <= '0;
         s1_rd   <= '0;
         s1_addr <= '0;
         s1_data <= '0;
      end else begin
         s1_vld <= s1_take;
         if (s1_take) begin
            s1_kind <= st_commit ? KIND_MEM : KIND_REG;
            s1_pc   <= commit_pc;
            s1_inst <= commit_inst;
            s1_rd   <= commit_Ard;
            s1_addr <= st_addr;
            s1_data <= st_commit ? store_lane(st_data, st_addr[1:0], commit_inst[14:12])
                                 : commit_data;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      pop      = 1'b0;
      chk_code = MIS_NONE;
      matched  = 1'b0;
      if (s1_vld && (state_q == CHECK)) begin
         if (empty) begin
            chk_code = MIS_UNDERFLOW;
         end else begin
            pop = 1'b1;
            if (head.kind != s1_kind)                       chk_code = MIS_KIND;
            else if (head.pc != s1_pc)                      chk_code = MIS_PC;
            else if (head.inst != s1_inst)                  chk_code = MIS_INST;
            else if ((s1_kind == KIND_REG) ? (head.rd != s1_rd)
                                           : (head.addr != s1_addr))
                                                            chk_code = MIS_RDADDR;
            else if (head.data != s1_data)                  chk_code = MIS_DATA;
         end
         if (chk_code != MIS_NONE) begin
            state_d = FAIL;
         end else begin
            matched = 1'b1;
            if (head.last) state_d = DONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= CHECK;
      else      state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mis_code    <= MIS_NONE;
         mis_pc      <= '0;
         match_count <= '0;
      end else begin
         if (chk_code != MIS_NONE) begin
            mis_code <= chk_code;
            mis_pc   <= s1_pc;
         end
         if (matched && (match_count != {CNT_W{1'b1}})) match_count <= match_count + 1'b1;
      end
   end

   assign mismatch = (state_q == FAIL);
   assign done     = (state_q == DONE);

endmodule

// File: doc/commit_checker.md
Name: commit_checker

Overview:
- Hardware reader of the per-commit trace stream: consumes golden commit records from a reference-model source over a valid/ready channel and compares each against the core's retired commits in real time.
- Sits beside the ROB commit port; uses the same commit/store-commit signals as the commit logger.
- Flags the first divergence with a sticky error and captured context, and counts matches for co-simulation and FPGA self-check.

Parameters:
- DEPTH, 8, golden-record FIFO entries (power of 2, ≥2)
- PC_BASE, 32'h2000, commits with pc < PC_BASE are neither checked nor popped
- CNT_W, 32, width of match_count

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset (0 = reset)
- commit_valid  in  1  ROB commit this cycle
- commit_pc  in  32  committed PC
- commit_inst  in  32  committed instruction
- commit_Ard  in  6  architectural destination
- commit_data  in  32  writeback value
- st_commit  in  1  committing instruction is a store
- st_addr  in  32  store address
- st_data  in  32  store data, lane-aligned to st_addr[1:0]
- gold_valid  in  1  golden record valid
- gold_ready  out  1  FIFO can accept
- gold_kind  in  1  0=REG, 1=MEM
- gold_pc  in  32  expected PC
- gold_inst  in  32  expected instruction
- gold_rd  in  6  expected rd (REG only)
- gold_addr  in  32  expected store address (MEM only)
- gold_data  in  32  expected reg value or right-justified store data
- gold_last  in  1  final record of trace
- mismatch  out  1  sticky error
- mis_code  out  3  0 none, 1 pc, 2 inst, 3 rd/addr, 4 data, 5 kind, 6 underflow
- mis_pc  out  32  core PC of first failing commit
- match_count  out  CNT_W  records matched
- done  out  1  last record matched, no error

Behaviour:
- Reset: all outputs 0 except gold_ready=1; FIFO empty; FSM=CHECK; stage-1 valid cleared. Reset mid-trace discards FIFO contents and the in-flight commit.
- gold_ready = !full && state==CHECK. Push when gold_valid && gold_ready. No push on full, even with a pop the same cycle.
- Stage 1 (edge N): latch a normalised commit only when commit_valid && commit_pc >= PC_BASE:
  - st_commit=1: kind=MEM; data = st_data >> 8*st_addr[1:0], masked by inst[14:12]: 000 → [7:0], 001 → [15:0], other → full 32 bits.
  - else if commit_Ard!=0 && inst[6:2]!=5'b11000: kind=REG, rd=Ard, data=commit_data.
  - else: no record; branches and x0 writes are skipped.
- Stage 2 (edge N+1): if a normalised record is valid and state==CHECK:
  - FIFO empty → FAIL, code 6.
  - Otherwise pop the head and compare fields in priority order: kind, pc, inst, rd (REG) or addr (MEM), data.
  - Mismatch → FAIL with the first failing code.
  - Match → match_count+1 (saturating). If head.last=1 → DONE.
- mismatch, mis_code, mis_pc update on edge N+1 and are visible the cycle after. Push and pop in the same cycle are legal when not full; the count is unchanged.
- FSM CHECK→FAIL on any error; CHECK→DONE on matched last. FAIL and DONE are terminal until reset, stop popping, and hold gold_ready=0.
- A commit arriving while in DONE is ignored. A pc below PC_BASE never pops the FIFO.
- Pointers are log2(DEPTH)+1 bits; they wrap naturally, and full/empty are decided by the MSB compare.

Decomposition:
- commit_pkg: typedef commit_rec_t {kind, pc, inst, rd, addr, data, last}; enum chk_state_e {CHECK, FAIL, DONE}; mis_code localparams; opcode constant BRANCH = 5'b11000.
- One sub-module: commit_rec_fifo (parameterised DEPTH, commit_rec_t payload, push/pop/full/empty).

Test Plan:
- Golden REG {pc 0x2000, inst 0x00500093, rd 1, data 5}; core commits the same → after 2 cycles match_count=1, mismatch=0.
- Golden MEM {addr 0x808F, data 0x78, inst funct3=000}; core st_addr 0x808F, st_data 0x78000000 → match. Repeat with golden data 0x79 → mismatch=1, mis_code=4, mis_pc=commit pc.
- Core branch commit (inst[6:2]=11000, Ard=0) and a commit at pc 0x1FFC, with one REG golden queued → FIFO not popped; the following REG commit matches.
- Loggable commit with FIFO empty → mis_code=6, gold_ready drops to 0 and stays 0.
- Fill 8 records with no commits → gold_ready=0 at full; 8 matching commits drain; the 8th has gold_last=1 → done=1, match_count=8.
- Assert rst=0 mid-trace with 3 records queued → all outputs cleared, gold_ready=1 immediately (async); a fresh trace then passes.
